// File: rtl/c499_sec_encoder_pkg.sv
// Shared constants, types and check-bit helper for the c499 32-bit SEC encoder.
package c499_sec_pkg;

  localparam int DATA_W        = 32;
  localparam int CHK_W         = 8;
  localparam int INJ_W         = 6;
  localparam int INJ_CHK_BASE  = 32;
  localparam int INJ_NONE_MIN  = 40;

  // Index i selects the data bits that feed check bit c[i].
  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASKS = {
    32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
    32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
  };

  // Nibble k covers d[4k+3:4k].
  localparam logic [CHK_W-1:0][DATA_W-1:0] NIB_MASKS = {
    32'hF0000000, 32'h0F000000, 32'h00F00000, 32'h000F0000,
    32'h0000F000, 32'h00000F00, 32'h000000F0, 32'h0000000F
  };

  // Column h*4+j covers d[16h+j], +4, +8, +12.
  localparam logic [CHK_W-1:0][DATA_W-1:0] COL_MASKS = {
    32'h88880000, 32'h44440000, 32'h22220000, 32'h11110000,
    32'h00008888, 32'h00004444, 32'h00002222, 32'h00001111
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [INJ_W-1:0]  inj;
    logic [CHK_W-1:0]  nib;
    logic [CHK_W-1:0]  col;
  } stage_a_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
  } stage_b_t;

  // Each check bit is one column parity of one half plus two nibble parities of the other.
  function automatic logic [CHK_W-1:0] combine_chk(input logic [CHK_W-1:0] nib,
                                                    input logic [CHK_W-1:0] col);
    logic [CHK_W-1:0] c;
    c[0] = col[0] ^ nib[4] ^ nib[5];
    c[1] = col[1] ^ nib[6] ^ nib[7];
    c[2] = col[2] ^ nib[4] ^ nib[6];
    c[3] = col[3] ^ nib[5] ^ nib[7];
    c[4] = col[4] ^ nib[0] ^ nib[1];
    c[5] = col[5] ^ nib[2] ^ nib[3];
    c[6] = col[6] ^ nib[0] ^ nib[2];
    c[7] = col[7] ^ nib[1] ^ nib[3];
    return c;
  endfunction

endpackage

// File: rtl/c499_sec_encoder_if.sv
// Input and output valid/ready channels of the SEC encoder.
interface c499_sec_encoder_if;
  import c499_sec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [INJ_W-1:0]  inj_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CHK_W-1:0]  out_check;

  modport slave (
    input  in_valid, in_data, inj_idx, out_ready,
    output in_ready, out_valid, out_data, out_check
  );

  modport master (
    output in_valid, in_data, inj_idx, out_ready,
    input  in_ready, out_valid, out_data, out_check
  );

endinterface

// File: rtl/c499_sec_encoder_parity.sv
// Mask-and-reduce parity: o_par[i] is the XOR of the data bits selected by MASKS[i].
module c499_sec_parity
  import c499_sec_pkg::*;
#(
  parameter logic [CHK_W-1:0][DATA_W-1:0] MASKS = CHK_MASKS
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_par
);

  always_comb begin
    o_par = '0;
    for (int i = 0; i < CHK_W; i++) begin
      o_par[i] = ^(i_data & MASKS[i]);
    end
  end

endmodule

// File: rtl/c499_sec_encoder.sv
// Two-stage c499 SEC check-bit generator with valid/ready handshake,
// optional single-bit fault injection and a saturating delivered-word counter.
module c499_sec_encoder
  import c499_sec_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  c499_sec_encoder_if.slave  bus,
  output logic [COUNT_W-1:0] words_out
);

  stage_a_t           r_a;
  stage_b_t           r_b;
  logic               r_a_valid;
  logic               r_b_valid;
  logic [COUNT_W-1:0] r_words;

  logic [CHK_W-1:0]   w_nib;
  logic [CHK_W-1:0]   w_col;
  logic               w_b_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  stage_b_t           w_b_next;

  c499_sec_parity #(.MASKS(NIB_MASKS)) u_nib (.i_data(bus.in_data), .o_par(w_nib));
  c499_sec_parity #(.MASKS(COL_MASKS)) u_col (.i_data(bus.in_data), .o_par(w_col));

  assign w_b_ready    = !r_b_valid || bus.out_ready;
  assign bus.in_ready = !r_a_valid || w_b_ready;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_out_fire   = r_b_valid && bus.out_ready;

  // Injection flips one bit of either field; indices 40..63 leave the codeword intact.
  always_comb begin
    w_b_next.data  = r_a.data;
    w_b_next.check = combine_chk(r_a.nib, r_a.col);
    if (r_a.inj < INJ_W'(INJ_CHK_BASE)) begin
      w_b_next.data[r_a.inj[4:0]] = ~w_b_next.data[r_a.inj[4:0]];
    end else if (r_a.inj < INJ_W'(INJ_NONE_MIN)) begin
      w_b_next.check[r_a.inj[2:0]] = ~w_b_next.check[r_a.inj[2:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a       <= '0;
    end else if (bus.in_ready) begin
      r_a_valid <= bus.in_valid;
      if (w_in_fire) begin
        r_a <= '{data: bus.in_data, inj: bus.inj_idx, nib: w_nib, col: w_col};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b       <= '0;
    end else if (w_b_ready) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b <= w_b_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words <= '0;
    end else if (w_out_fire && (r_words != '1)) begin
      r_words <= r_words + 1'b1;
    end
  end

  assign bus.out_valid = r_b_valid;
  assign bus.out_data  = r_b.data;
  assign bus.out_check = r_b.check;
  assign words_out     = r_words;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Directed self-checking bench for c499_sec_encoder: known vectors, streaming,
// backpressure, reset flush and counter saturation.
module tb_c499_sec_encoder;
  import c499_sec_pkg::*;

  localparam int COUNT_W = 16;
  localparam int NDIR    = 11;

  logic               clk;
  logic               rst_n;
  logic [COUNT_W-1:0] words_out;
  logic [CHK_W-1:0]   ref_par;

  c499_sec_encoder_if bus ();

  c499_sec_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .words_out (words_out)
  );

  // Reference syndrome source: check bits recomputed from the emitted data.
  c499_sec_parity u_ref (.i_data(bus.out_data), .o_par(ref_par));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [31:0] q[$];

  logic [31:0] dir_data [NDIR] = '{32'h00000000, 32'h00000001, 32'h00010000, 32'hFFFFFFFF,
                                   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                                   32'h00000000, 32'h00000000, 32'h00000001};
  logic [5:0]  dir_inj  [NDIR] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd35, 6'd5, 6'd31, 6'd32,
                                   6'd39, 6'd40, 6'd32};
  logic [31:0] exp_data [NDIR] = '{32'h00000000, 32'h00000001, 32'h00010000, 32'hFFFFFFFF,
                                   32'h00000000, 32'h00000020, 32'h80000000, 32'h00000000,
                                   32'h00000000, 32'h00000000, 32'h00000001};
  logic [7:0]  exp_chk  [NDIR] = '{8'h00, 8'h51, 8'h15, 8'h00, 8'h08, 8'h00, 8'h00, 8'h01,
                                   8'h80, 8'h00, 8'h50};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with streaming scoreboard: compares any output transfer, records any input transfer.
  task automatic do_cycle(output bit acc);
    logic [31:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("fifo_data", 64'(bus.out_data), 64'(e));
        chk("syndrome", 64'(ref_par ^ bus.out_check), 64'd0);
        n_out++;
      end
    end
    if (acc) q.push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc;
    int          exp_words;
    int          sent;
    int          n_acc;
    logic [31:0] bp_words [4];

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_idx   = 6'd63;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_check", 64'(bus.out_check), 64'd0);
    chk("rst_words_out", 64'(words_out), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors through an empty pipeline
    exp_words = 0;
    for (int i = 0; i < NDIR; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = dir_data[i];
      bus.inj_idx  = dir_inj[i];
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hDEADBEEF;
      bus.inj_idx  = 6'd0;
      chk("lat_not_yet", 64'(bus.out_valid), 64'd0);
      step();
      chk("lat_valid", 64'(bus.out_valid), 64'd1);
      chk("dir_data", 64'(bus.out_data), 64'(exp_data[i]));
      chk("dir_check", 64'(bus.out_check), 64'(exp_chk[i]));
      step();
      exp_words++;
      chk("dir_words", 64'(words_out), 64'(exp_words));
      chk("dir_drained", 64'(bus.out_valid), 64'd0);
    end

    // Back-to-back streaming with out_ready held high
    n_out = 0;
    n_acc = 0;
    bus.inj_idx = 6'd63;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      do_cycle(acc);
      if (acc) n_acc++;
    end
    chk("stream_accepts", 64'(n_acc), 64'd100);
    chk("stream_rate", 64'(n_out), 64'd98);
    bus.in_valid = 1'b0;
    repeat (2) do_cycle(acc);
    chk("stream_total", 64'(n_out), 64'd100);
    exp_words += 100;
    chk("stream_words", 64'(words_out), 64'(exp_words));

    // Backpressure: four offers into a stalled pipeline
    for (int i = 0; i < 4; i++) bp_words[i] = 32'hA5000000 | 32'(i);
    bus.out_ready = 1'b0;
    sent = 0;
    n_out = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (sent < 4);
      bus.in_data  = bp_words[sent < 4 ? sent : 3];
      if (c >= 2) begin
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_out_hold", 64'(bus.out_data), 64'(bp_words[0]));
      end
      do_cycle(acc);
      if (acc) sent++;
    end
    chk("bp_accepted", 64'(sent), 64'd2);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (sent < 4);
      bus.in_data  = bp_words[sent < 4 ? sent : 3];
      do_cycle(acc);
      if (acc) sent++;
    end
    chk("bp_sent_all", 64'(sent), 64'd4);
    chk("bp_drained", 64'(n_out), 64'd4);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);
    exp_words += 4;
    chk("bp_words", 64'(words_out), 64'(exp_words));

    // Reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    do_cycle(acc);
    bus.in_data   = 32'h9ABCDEF0;
    do_cycle(acc);
    bus.in_valid  = 1'b0;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_words", 64'(words_out), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    q.delete();
    n_out = 0;
    bus.out_ready = 1'b1;
    repeat (5) do_cycle(acc);
    chk("no_stale_out", 64'(n_out), 64'd0);
    chk("post_rst_words", 64'(words_out), 64'd0);

    // Counter saturation: 2^COUNT_W + 3 output transfers
    bus.in_valid = 1'b1;
    for (int i = 0; i < (1 << COUNT_W) + 3; i++) begin
      bus.in_data = $urandom;
      do_cycle(acc);
    end
    bus.in_valid = 1'b0;
    repeat (3) do_cycle(acc);
    chk("sat_transfers", 64'(n_out), 64'((1 << COUNT_W) + 3));
    chk("sat_words", 64'(words_out), 64'({COUNT_W{1'b1}}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
